// File: rtl/fft_bin_avg.sv
// Spectrum-averaging buffer: aligns FFT frames to a common exponent, accumulates 2^AVG_LOG2 frames
// and publishes the averages into a double-buffered read bank. Define FFT_BIN_AVG_SAT_EN to saturate on publish.
module fft_bin_avg #(
  parameter int DATA_W    = 16,
  parameter int NFFT_LOG2 = 12,
  parameter int BINS      = 2800,
  parameter int AVG_LOG2  = 2,
  parameter int EXP_MAX   = 7,
  parameter int OUT_SHIFT = 0,
  parameter int ADDR_W    = 12
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic                  cont,
  input  logic                  stop,
  input  logic [2*DATA_W-1:0]   s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  input  logic [NFFT_LOG2-1:0]  s_index,
  input  logic [4:0]            s_blk_exp,
  output logic                  busy,
  output logic                  done,
  output logic                  bank_valid,
  output logic [AVG_LOG2:0]     frame_cnt,
  output logic                  ovf,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_re,
  output logic [DATA_W-1:0]     rd_im
);

  localparam int ACC_W  = DATA_W + EXP_MAX + AVG_LOG2 + 1;
  localparam int SH     = AVG_LOG2 + OUT_SHIFT;
  localparam int FMAX_I = 1 << AVG_LOG2;
  localparam logic [AVG_LOG2:0] FMAX = FMAX_I[AVG_LOG2:0];
`ifdef FFT_BIN_AVG_SAT_EN
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
`endif

  typedef enum logic [1:0] {IDLE, SYNC, ACCUM, PUBLISH} state_t;

  state_t              state_q, state_d;
  logic [AVG_LOG2:0]   frame_cnt_q, frame_cnt_d, fc_inc;
  logic                ovf_q, ovf_d, cont_q, cont_d, stop_q, stop_d;
  logic                front_q, front_d, bank_valid_q, bank_valid_d;
  logic [DATA_W-1:0]   rd_re_q, rd_im_q;

  // accept-stage (T) and write-stage (T+1) pipeline
  logic                    p1_vld_q, p1_first_q, p1_last_q;
  logic [ADDR_W-1:0]       p1_addr_q;
  logic signed [ACC_W-1:0] p1_xre_q, p1_xim_q, acc_rd_re_q, acc_rd_im_q;

  logic signed [ACC_W-1:0] acc_re [BINS];
  logic signed [ACC_W-1:0] acc_im [BINS];
  logic [DATA_W-1:0]       bank_re [2][BINS];
  logic [DATA_W-1:0]       bank_im [2][BINS];

  logic                    accept, in_rng, e_big, rd_sel, sat_hit;
  logic [4:0]              e_use;
  logic signed [ACC_W-1:0] x_re, x_im, sum_re, sum_im;
  logic [DATA_W-1:0]       out_re, out_im;
`ifdef FFT_BIN_AVG_SAT_EN
  logic signed [ACC_W-1:0] res_re, res_im;
`endif

  assign accept = s_tvalid && ((state_q == SYNC && s_index == '0) ||
                               (state_q == ACCUM && frame_cnt_q != FMAX));
  assign in_rng = 32'(s_index) < 32'(BINS);
  assign e_big  = s_blk_exp > 5'(EXP_MAX);
  assign e_use  = e_big ? 5'(EXP_MAX) : s_blk_exp;
  assign fc_inc = frame_cnt_q + 1'b1;
  assign x_re   = $signed({{(ACC_W-DATA_W){s_tdata[DATA_W-1]}}, s_tdata[DATA_W-1:0]}) <<< e_use;
  assign x_im   = $signed({{(ACC_W-DATA_W){s_tdata[2*DATA_W-1]}}, s_tdata[2*DATA_W-1:DATA_W]}) <<< e_use;

  assign busy       = state_q != IDLE;
  assign done       = state_q == PUBLISH;
  assign bank_valid = bank_valid_q | done;
  assign frame_cnt  = frame_cnt_q;
  assign ovf        = ovf_q;
  assign rd_re      = rd_re_q;
  assign rd_im      = rd_im_q;
  // the read sampled during PUBLISH already sees the freshly published bank
  assign rd_sel     = done ? ~front_q : front_q;

  always_comb begin
    sum_re = p1_first_q ? p1_xre_q : acc_rd_re_q + p1_xre_q;
    sum_im = p1_first_q ? p1_xim_q : acc_rd_im_q + p1_xim_q;
`ifdef FFT_BIN_AVG_SAT_EN
    res_re  = sum_re >>> SH;
    res_im  = sum_im >>> SH;
    out_re  = (res_re > MAXV) ? MAXV[DATA_W-1:0] : (res_re < MINV) ? MINV[DATA_W-1:0] : res_re[DATA_W-1:0];
    out_im  = (res_im > MAXV) ? MAXV[DATA_W-1:0] : (res_im < MINV) ? MINV[DATA_W-1:0] : res_im[DATA_W-1:0];
    sat_hit = p1_vld_q && p1_last_q &&
              (res_re > MAXV || res_re < MINV || res_im > MAXV || res_im < MINV);
`else
    out_re  = DATA_W'(sum_re >>> SH);
    out_im  = DATA_W'(sum_im >>> SH);
    sat_hit = 1'b0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    ovf_d        = ovf_q;
    cont_d       = cont_q;
    stop_d       = stop_q;
    front_d      = front_q;
    bank_valid_d = bank_valid_q;
    case (state_q)
      IDLE: if (start) begin
        state_d     = SYNC;
        frame_cnt_d = '0;
        ovf_d       = 1'b0;
        cont_d      = cont;
        stop_d      = 1'b0;
      end
      SYNC:  if (accept) state_d = ACCUM;
      // final frame counted: one cycle lets the last write land before publishing
      ACCUM: if (frame_cnt_q == FMAX) state_d = PUBLISH;
      PUBLISH: begin
        front_d      = ~front_q;
        bank_valid_d = 1'b1;
        if (cont_q && !(stop_q || stop)) begin
          state_d     = SYNC;
          frame_cnt_d = '0;
          ovf_d       = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept && s_tlast) begin
      frame_cnt_d = fc_inc;
      state_d     = (fc_inc == FMAX) ? ACCUM : SYNC;
    end
    if ((accept && in_rng && e_big) || sat_hit) ovf_d = 1'b1;
    if (state_q != IDLE && stop) stop_d = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      frame_cnt_q  <= '0;
      ovf_q        <= 1'b0;
      cont_q       <= 1'b0;
      stop_q       <= 1'b0;
      front_q      <= 1'b0;
      bank_valid_q <= 1'b0;
      p1_vld_q     <= 1'b0;
      rd_re_q      <= '0;
      rd_im_q      <= '0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      ovf_q        <= ovf_d;
      cont_q       <= cont_d;
      stop_q       <= stop_d;
      front_q      <= front_d;
      bank_valid_q <= bank_valid_d;
      p1_vld_q     <= accept && in_rng;
      rd_re_q      <= bank_re[rd_sel][rd_addr];
      rd_im_q      <= bank_im[rd_sel][rd_addr];
    end
  end

  always_ff @(posedge sys_clk) begin
    acc_rd_re_q <= acc_re[s_index[ADDR_W-1:0]];
    acc_rd_im_q <= acc_im[s_index[ADDR_W-1:0]];
    p1_addr_q   <= s_index[ADDR_W-1:0];
    p1_xre_q    <= x_re;
    p1_xim_q    <= x_im;
    p1_first_q  <= frame_cnt_q == '0;
    p1_last_q   <= fc_inc == FMAX;
    if (p1_vld_q) begin
      acc_re[p1_addr_q] <= sum_re;
      acc_im[p1_addr_q] <= sum_im;
      if (p1_last_q) begin
        bank_re[~front_q][p1_addr_q] <= out_re;
        bank_im[~front_q][p1_addr_q] <= out_im;
      end
    end
  end

endmodule
